// File: rtl/network_mul_share_arbiter.sv
// Round-robin arbiter sharing one external pipelined signed multiplier between
// NUM_REQ requesters. Each issue is tagged with its requester id; the tag pipe
// mirrors the multiplier register stages so products return in issue order.
// Backpressure on the response port freezes the multiplier and the tag pipe.
module network_mul_share_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = 2,
   parameter int unsigned A_WIDTH  = 16,
   parameter int unsigned B_WIDTH  = 10,
   parameter int unsigned P_WIDTH  = 26,
   parameter int unsigned MUL_LAT  = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_WIDTH-1:0]        rsp_id,
   output logic [P_WIDTH-1:0]         rsp_p,
   output logic                       mul_ce,
   output logic [A_WIDTH-1:0]         mul_din0,
   output logic [B_WIDTH-1:0]         mul_din1,
   input  logic [P_WIDTH-1:0]         mul_dout,
   output logic                       busy
);

   // Tag pipe: one {vld, id} entry per multiplier register stage.
   logic [MUL_LAT-1:0]  r_vld;
   logic [ID_WIDTH-1:0] r_id [MUL_LAT];
   logic [ID_WIDTH-1:0] r_rr_ptr;

   logic                w_hi_found;
   logic [ID_WIDTH-1:0] w_hi_id;
   logic [ID_WIDTH-1:0] w_lo_id;
   logic [ID_WIDTH-1:0] w_grant_id;
   logic                w_issue;

   // Response side and global stall: a held head freezes the whole pipe.
   always_comb begin
      rsp_valid = r_vld[MUL_LAT-1];
      rsp_id    = r_id[MUL_LAT-1];
      rsp_p     = mul_dout;
      mul_ce    = ~(rsp_valid & ~rsp_ready);
      busy      = |r_vld;
   end

   // Round-robin search: lowest valid id above r_rr_ptr wins, otherwise the
   // lowest valid id at or below it (wrap-around). Descending loop keeps the lowest.
   always_comb begin
      w_hi_found = 1'b0;
      w_hi_id    = '0;
      w_lo_id    = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (ID_WIDTH'(i) > r_rr_ptr) begin
               w_hi_found = 1'b1;
               w_hi_id    = ID_WIDTH'(i);
            end else begin
               w_lo_id = ID_WIDTH'(i);
            end
         end
      end
      w_grant_id = w_hi_found ? w_hi_id : w_lo_id;
      w_issue    = (|req_valid) & mul_ce;
   end

   // Grant decode and operand mux; operands are zero when nothing issues.
   always_comb begin
      req_ready = '0;
      mul_din0  = '0;
      mul_din1  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (w_issue && (w_grant_id == ID_WIDTH'(i))) begin
            req_ready[i] = 1'b1;
            mul_din0     = req_a[i*A_WIDTH +: A_WIDTH];
            mul_din1     = req_b[i*B_WIDTH +: B_WIDTH];
         end
      end
   end

   // Tag pipe and round-robin pointer advance in lockstep with mul_ce.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld    <= '0;
         r_rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
         for (int s = 0; s < int'(MUL_LAT); s++) begin
            r_id[s] <= '0;
         end
      end else if (mul_ce) begin
         r_vld[0] <= w_issue;
         r_id[0]  <= w_grant_id;
         for (int s = 1; s < int'(MUL_LAT); s++) begin
            r_vld[s] <= r_vld[s-1];
            r_id[s]  <= r_id[s-1];
         end
         if (w_issue) begin
            r_rr_ptr <= w_grant_id;
         end
      end
   end

endmodule
